// File: rtl/clk_window_ctrl_pkg.sv
// Shared definitions for the measurement-window controller and its up counter.
package clk_window_ctrl_pkg;

   localparam int CNT_WIDTH = 8;
   localparam int WIN_WIDTH = 16;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_CLEAR   = 3'd1;
   localparam logic [2:0] ST_COUNT   = 3'd2;
   localparam logic [2:0] ST_CAPTURE = 3'd3;
   localparam logic [2:0] ST_HOLD    = 3'd4;

   typedef enum logic [2:0] {
      IDLE    = ST_IDLE,
      CLEAR   = ST_CLEAR,
      COUNT   = ST_COUNT,
      CAPTURE = ST_CAPTURE,
      HOLD    = ST_HOLD
   } state_t;

endpackage

// File: rtl/clk_window_ctrl_if.sv
// Host-side bundle of the window controller: request, event qualifier and result handshake.
interface clk_window_ctrl_if #(
   parameter int WIDTH = clk_window_ctrl_pkg::CNT_WIDTH,
   parameter int WIN_W = clk_window_ctrl_pkg::WIN_WIDTH
);

   logic             start;
   logic [WIN_W-1:0] win_len;
   logic             abort;
   logic             event_in;
   logic             busy;
   logic [WIDTH-1:0] result;
   logic             overflow;
   logic             res_valid;
   logic             res_ready;

   // Result handshake: res_valid rises with result/overflow already stable and holds
   // them frozen until the edge where res_ready (or abort) is sampled high.
   modport master (
      output start, win_len, abort, event_in, res_ready,
      input  busy, result, overflow, res_valid
   );

   modport slave (
      input  start, win_len, abort, event_in, res_ready,
      output busy, result, overflow, res_valid
   );

endinterface

// File: rtl/clk_window_ctrl_counter.sv
// Free-running WIDTH-bit up counter with synchronous clear; the controller drives en/clr.
module clk_window_ctrl_counter #(
   parameter int WIDTH = clk_window_ctrl_pkg::CNT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             clr,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/clk_window_ctrl.sv
// Measurement-window controller: clears the counter, gates event_in for win_len cycles,
// then captures the count and offers it on a valid/ready handshake with a sticky overflow.
module clk_window_ctrl
   import clk_window_ctrl_pkg::*;
#(
   parameter int WIDTH = CNT_WIDTH,
   parameter int WIN_W = WIN_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   clk_window_ctrl_if.slave bus,
   input  logic [WIDTH-1:0] cnt_in,
   output logic             cnt_en,
   output logic             cnt_clr,
   output state_t           state_dbg
);

   localparam logic [WIN_W-1:0] REM_ONE = WIN_W'(1);

   state_t           state;
   logic [WIN_W-1:0] rem;
   logic             busy_q;
   logic [WIDTH-1:0] result_q;
   logic             overflow_q;
   logic             res_valid_q;

   // Abort wins over counting in the same cycle so the counter is never enabled while cancelling.
   assign cnt_en        = (state == COUNT) && bus.event_in && !bus.abort;
   assign bus.busy      = busy_q;
   assign bus.result    = result_q;
   assign bus.overflow  = overflow_q;
   assign bus.res_valid = res_valid_q;
   assign state_dbg     = state;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         rem         <= '0;
         cnt_clr     <= 1'b0;
         busy_q      <= 1'b0;
         result_q    <= '0;
         overflow_q  <= 1'b0;
         res_valid_q <= 1'b0;
      end else begin
         cnt_clr <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  rem     <= bus.win_len;
                  cnt_clr <= 1'b1;
                  busy_q  <= 1'b1;
                  state   <= CLEAR;
               end
            end
            CLEAR: begin
               overflow_q <= 1'b0;
               if (bus.abort) begin
                  cnt_clr <= 1'b1;
                  busy_q  <= 1'b0;
                  state   <= IDLE;
               end else if (rem == '0) begin
                  state <= CAPTURE;
               end else begin
                  state <= COUNT;
               end
            end
            COUNT: begin
               if (bus.abort) begin
                  cnt_clr <= 1'b1;
                  busy_q  <= 1'b0;
                  state   <= IDLE;
               end else begin
                  if (cnt_en && (&cnt_in)) begin
                     overflow_q <= 1'b1;
                  end
                  if (rem != '0) begin
                     rem <= rem - REM_ONE;
                  end
                  if (rem <= REM_ONE) begin
                     state <= CAPTURE;
                  end
               end
            end
            CAPTURE: begin
               // The last increment lands on cnt_in one cycle after the final cnt_en.
               if (bus.abort) begin
                  cnt_clr <= 1'b1;
                  busy_q  <= 1'b0;
                  state   <= IDLE;
               end else begin
                  result_q    <= cnt_in;
                  res_valid_q <= 1'b1;
                  state       <= HOLD;
               end
            end
            HOLD: begin
               if (bus.abort || bus.res_ready) begin
                  res_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: begin
               busy_q      <= 1'b0;
               res_valid_q <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_clk_window_ctrl.sv
// Bench for clk_window_ctrl driving the companion up counter; table of windows plus corner sequences.
module tb_clk_window_ctrl;
   import clk_window_ctrl_pkg::*;

   localparam int WIDTH = 8;
   localparam int WIN_W = 16;

   logic             clk = 1'b0;
   logic             reset;
   logic             cnt_rst;
   logic [WIDTH-1:0] count;
   logic             cnt_en;
   logic             cnt_clr;
   state_t           state_dbg;

   int checks = 0;
   int errors = 0;

   clk_window_ctrl_if #(.WIDTH(WIDTH), .WIN_W(WIN_W)) bus ();

   clk_window_ctrl #(.WIDTH(WIDTH), .WIN_W(WIN_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .cnt_in    (count),
      .cnt_en    (cnt_en),
      .cnt_clr   (cnt_clr),
      .state_dbg (state_dbg)
   );

   clk_window_ctrl_counter #(.WIDTH(WIDTH)) u_cnt (
      .clk   (clk),
      .reset (cnt_rst),
      .en    (cnt_en),
      .clr   (cnt_clr),
      .count (count)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      int win_len;
      int mode;        // 0 all ones, 1 toggle 1,0, 2 none, 3 every third
      int exp_result;
      int exp_ovf;
      int hold_dly;
      bit stray;       // pulse start mid-COUNT and at the release edge
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic pat(input int mode, input int k);
      case (mode)
         0:       return 1'b1;
         1:       return (k % 2) == 0;
         3:       return (k % 3) == 0;
         default: return 1'b0;
      endcase
   endfunction

   task automatic run_vec(input vec_t v);
      int lat = -1;
      int en_cnt = 0;
      int clr_cnt = 0;
      int overlap = 0;
      int exp_en = 0;
      for (int k = 0; k < v.win_len; k++) exp_en += int'(pat(v.mode, k));
      @(posedge clk); #1;
      bus.win_len  = WIN_W'(v.win_len);
      bus.start    = 1'b1;
      bus.event_in = 1'b0;
      for (int j = 1; j <= v.win_len + 20; j++) begin
         @(posedge clk); #1;
         bus.start = v.stray && (j == 4);
         if (v.stray && j == 4) bus.win_len = WIN_W'(2);
         bus.event_in = (j >= 2) ? pat(v.mode, j - 2) : 1'b0;
         @(negedge clk);
         en_cnt  += int'(cnt_en);
         clr_cnt += int'(cnt_clr);
         if (cnt_en && cnt_clr) overlap++;
         if (bus.res_valid) begin
            lat = j;
            break;
         end
      end
      bus.event_in = 1'b0;
      check($sformatf("latency_w%0d", v.win_len), lat, v.win_len + 3);
      check($sformatf("en_cycles_w%0d", v.win_len), en_cnt, exp_en);
      check($sformatf("clr_pulses_w%0d", v.win_len), clr_cnt, 1);
      check($sformatf("clr_en_overlap_w%0d", v.win_len), overlap, 0);
      check($sformatf("result_w%0d", v.win_len), int'(bus.result), v.exp_result);
      check($sformatf("overflow_w%0d", v.win_len), int'(bus.overflow), v.exp_ovf);
      repeat (v.hold_dly) begin
         @(posedge clk); #1;
      end
      @(negedge clk);
      check($sformatf("hold_result_w%0d", v.win_len), int'(bus.result), v.exp_result);
      check($sformatf("hold_valid_w%0d", v.win_len), int'(bus.res_valid), 1);
      check($sformatf("hold_busy_w%0d", v.win_len), int'(bus.busy), 1);
      @(posedge clk); #1;
      bus.res_ready = 1'b1;
      bus.start     = v.stray;
      @(posedge clk); #1;
      bus.res_ready = 1'b0;
      bus.start     = 1'b0;
      @(negedge clk);
      check($sformatf("release_valid_w%0d", v.win_len), int'(bus.res_valid), 0);
      check($sformatf("release_state_w%0d", v.win_len), int'(state_dbg), int'(ST_IDLE));
      @(posedge clk); #1;
      @(negedge clk);
      check($sformatf("idle_busy_w%0d", v.win_len), int'(bus.busy), 0);
   endtask

   initial begin
      int seen;
      vecs[0] = '{win_len: 5,   mode: 0, exp_result: 5,   exp_ovf: 0, hold_dly: 0, stray: 1'b0};
      vecs[1] = '{win_len: 10,  mode: 1, exp_result: 5,   exp_ovf: 0, hold_dly: 4, stray: 1'b1};
      vecs[2] = '{win_len: 300, mode: 0, exp_result: 44,  exp_ovf: 1, hold_dly: 0, stray: 1'b0};
      vecs[3] = '{win_len: 0,   mode: 0, exp_result: 0,   exp_ovf: 0, hold_dly: 0, stray: 1'b0};
      vecs[4] = '{win_len: 255, mode: 0, exp_result: 255, exp_ovf: 0, hold_dly: 0, stray: 1'b0};
      vecs[5] = '{win_len: 256, mode: 0, exp_result: 0,   exp_ovf: 1, hold_dly: 1, stray: 1'b0};
      vecs[6] = '{win_len: 7,   mode: 2, exp_result: 0,   exp_ovf: 0, hold_dly: 0, stray: 1'b0};
      vecs[7] = '{win_len: 9,   mode: 3, exp_result: 3,   exp_ovf: 0, hold_dly: 2, stray: 1'b0};
      vecs[8] = '{win_len: 1,   mode: 0, exp_result: 1,   exp_ovf: 0, hold_dly: 0, stray: 1'b0};

      // clock/reset
      reset         = 1'b1;
      cnt_rst       = 1'b1;
      bus.start     = 1'b0;
      bus.win_len   = '0;
      bus.abort     = 1'b0;
      bus.event_in  = 1'b0;
      bus.res_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_state", int'(state_dbg), int'(ST_IDLE));
      check("reset_busy", int'(bus.busy), 0);
      check("reset_valid", int'(bus.res_valid), 0);
      check("reset_result", int'(bus.result), 0);
      check("reset_overflow", int'(bus.overflow), 0);
      check("reset_cnt_clr", int'(cnt_clr), 0);
      check("reset_cnt_en", int'(cnt_en), 0);
      @(posedge clk); #1;
      reset   = 1'b0;
      cnt_rst = 1'b0;

      foreach (vecs[i]) run_vec(vecs[i]);

      // abort in IDLE does nothing
      @(posedge clk); #1;
      bus.abort = 1'b1;
      @(posedge clk); #1;
      bus.abort = 1'b0;
      @(negedge clk);
      check("idle_abort_clr", int'(cnt_clr), 0);
      check("idle_abort_state", int'(state_dbg), int'(ST_IDLE));

      // abort on the 3rd COUNT cycle of an 8-cycle window
      @(posedge clk); #1;
      bus.win_len  = WIN_W'(8);
      bus.start    = 1'b1;
      bus.event_in = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      @(posedge clk); #1;
      bus.abort = 1'b1;
      @(negedge clk);
      check("abort_in_count_state", int'(state_dbg), int'(ST_COUNT));
      check("abort_gates_en", int'(cnt_en), 0);
      check("abort_count_before", int'(count), 2);
      @(posedge clk); #1;
      bus.abort    = 1'b0;
      bus.event_in = 1'b0;
      @(negedge clk);
      check("abort_clr_pulse", int'(cnt_clr), 1);
      check("abort_state_idle", int'(state_dbg), int'(ST_IDLE));
      check("abort_busy", int'(bus.busy), 0);
      @(posedge clk); #1;
      @(negedge clk);
      check("abort_clr_one_cycle", int'(cnt_clr), 0);
      check("abort_counter_zero", int'(count), 0);
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         seen += int'(bus.res_valid);
      end
      check("abort_no_valid", seen, 0);

      // abort in HOLD wins over res_ready
      @(posedge clk); #1;
      bus.win_len  = WIN_W'(2);
      bus.start    = 1'b1;
      bus.event_in = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      seen = 0;
      for (int j = 0; j < 20; j++) begin
         @(negedge clk);
         if (bus.res_valid) begin
            seen = 1;
            break;
         end
      end
      bus.event_in = 1'b0;
      check("hold_abort_reached", seen, 1);
      check("hold_abort_result", int'(bus.result), 2);
      @(posedge clk); #1;
      bus.abort     = 1'b1;
      bus.res_ready = 1'b1;
      @(posedge clk); #1;
      bus.abort     = 1'b0;
      bus.res_ready = 1'b0;
      @(negedge clk);
      check("hold_abort_valid", int'(bus.res_valid), 0);
      check("hold_abort_state", int'(state_dbg), int'(ST_IDLE));
      check("hold_abort_no_clr", int'(cnt_clr), 0);

      // reset mid-COUNT; counter keeps its value
      @(posedge clk); #1;
      bus.win_len  = WIN_W'(20);
      bus.start    = 1'b1;
      bus.event_in = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      bus.event_in = 1'b0;
      @(negedge clk);
      check("midrst_state", int'(state_dbg), int'(ST_IDLE));
      check("midrst_busy", int'(bus.busy), 0);
      check("midrst_result", int'(bus.result), 0);
      check("midrst_valid", int'(bus.res_valid), 0);
      check("midrst_overflow", int'(bus.overflow), 0);
      check("midrst_cnt_clr", int'(cnt_clr), 0);
      check("midrst_counter_kept", int'(count), 5);
      @(posedge clk); #1;
      reset = 1'b0;
      run_vec('{win_len: 4, mode: 0, exp_result: 4, exp_ovf: 0, hold_dly: 0, stray: 1'b0});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
